// File: rtl/brus16_pkg.sv
// Shared definitions for the brus16 data-memory path.
// Holds the DMA arbiter state encoding and the memory geometry.
package brus16_pkg;

  localparam int DATA_WIDTH = 13;
  localparam int WORD_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_dma_arbiter.sv
// Shares the data bsram between the CPU and a per-frame video DMA burst.
// On vblank_start the CPU is halted, DMA_LEN words are streamed out, and
// the CPU's held read is re-issued before it is released.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   vblank_start        : one-cycle burst request
//   cpu_mem_*           : CPU read/write side
//   cpu_halt            : registered CPU freeze
//   mem_*               : bsram ports (1-cycle read latency)
//   dma_valid/index/data: fetched word stream
//   dma_done            : pulse one cycle after the last word
module mem_dma_arbiter
  import brus16_pkg::*;
#(
  parameter int DATA_WIDTH = brus16_pkg::DATA_WIDTH,
  parameter int WORD_WIDTH = brus16_pkg::WORD_WIDTH,
  parameter int DMA_BASE   = 7680,
  parameter int DMA_LEN    = 512,
  parameter int IDX_WIDTH  = (DMA_LEN > 1) ? $clog2(DMA_LEN) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vblank_start,
  input  logic [DATA_WIDTH-1:0] cpu_mem_din_addr,
  output logic [WORD_WIDTH-1:0] cpu_mem_din,
  input  logic                  cpu_mem_dout_we,
  input  logic [DATA_WIDTH-1:0] cpu_mem_dout_addr,
  input  logic [WORD_WIDTH-1:0] cpu_mem_dout,
  output logic                  cpu_halt,
  output logic [DATA_WIDTH-1:0] mem_dout_addr,
  input  logic [WORD_WIDTH-1:0] mem_dout,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_din_addr,
  output logic [WORD_WIDTH-1:0] mem_din,
  output logic                  dma_valid,
  output logic [IDX_WIDTH-1:0]  dma_index,
  output logic [WORD_WIDTH-1:0] dma_data,
  output logic                  dma_done
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX =
    IDX_WIDTH'(DMA_LEN - 1);
  localparam logic [DATA_WIDTH-1:0] BASE_ADDR =
    DATA_WIDTH'(DMA_BASE);

  arb_state_e           state_q, state_d;
  logic [IDX_WIDTH-1:0] counter_q, counter_d;
  logic                 cpu_halt_q, cpu_halt_d;
  logic                 dma_valid_q, dma_valid_d;
  logic [IDX_WIDTH-1:0] dma_index_q, dma_index_d;
  logic                 dma_done_q, dma_done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      counter_q   <= '0;
      cpu_halt_q  <= 1'b0;
      dma_valid_q <= 1'b0;
      dma_index_q <= '0;
      dma_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      cpu_halt_q  <= cpu_halt_d;
      dma_valid_q <= dma_valid_d;
      dma_index_q <= dma_index_d;
      dma_done_q  <= dma_done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    counter_d     = counter_q;
    cpu_halt_d    = cpu_halt_q;
    dma_valid_d   = 1'b0;
    dma_index_d   = dma_index_q;
    dma_done_d    = 1'b0;
    mem_dout_addr = cpu_mem_din_addr;
    unique case (state_q)
      IDLE: begin
        // vblank during FETCH/DRAIN falls through the other arms
        if (vblank_start) begin
          state_d    = FETCH;
          counter_d  = '0;
          cpu_halt_d = 1'b1;
        end
      end
      FETCH: begin
        // base + offset wraps at the top of the address space
        mem_dout_addr = BASE_ADDR + DATA_WIDTH'(counter_q);
        dma_valid_d   = 1'b1;
        dma_index_d   = counter_q;
        if (counter_q == LAST_IDX) begin
          state_d   = DRAIN;
          counter_d = '0;
        end else begin
          counter_d = counter_q + IDX_WIDTH'(1);
        end
      end
      DRAIN: begin
        // re-issue the CPU read so its data is ready on release
        state_d    = IDLE;
        cpu_halt_d = 1'b0;
        dma_done_d = 1'b1;
      end
      default: begin
        state_d    = IDLE;
        cpu_halt_d = 1'b0;
      end
    endcase
  end

  assign cpu_mem_din  = mem_dout;
  assign mem_din_addr = cpu_mem_dout_addr;
  assign mem_din      = cpu_mem_dout;
  assign mem_we       = cpu_mem_dout_we & ~cpu_halt_q;

  assign cpu_halt  = cpu_halt_q;
  assign dma_valid = dma_valid_q;
  assign dma_index = dma_index_q;
  // read data arrives one cycle after the FETCH address
  assign dma_data  = dma_valid_q ? mem_dout : '0;
  assign dma_done  = dma_done_q;

endmodule

// File: tb/tb_mem_dma_arbiter.sv
// Scoreboard bench for mem_dma_arbiter with a wrapping 4-word burst.
// Models the bsram with a 1-cycle registered read.
module tb_mem_dma_arbiter;

  localparam int DW   = 13;
  localparam int WW   = 16;
  localparam int BASE = 8190;
  localparam int LEN  = 4;
  localparam int IW   = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          vblank_start;
  logic [DW-1:0] cpu_mem_din_addr;
  logic [WW-1:0] cpu_mem_din;
  logic          cpu_mem_dout_we;
  logic [DW-1:0] cpu_mem_dout_addr;
  logic [WW-1:0] cpu_mem_dout;
  logic          cpu_halt;
  logic [DW-1:0] mem_dout_addr;
  logic [WW-1:0] mem_dout;
  logic          mem_we;
  logic [DW-1:0] mem_din_addr;
  logic [WW-1:0] mem_din;
  logic          dma_valid;
  logic [IW-1:0] dma_index;
  logic [WW-1:0] dma_data;
  logic          dma_done;

  mem_dma_arbiter #(
    .DATA_WIDTH(DW), .WORD_WIDTH(WW),
    .DMA_BASE(BASE), .DMA_LEN(LEN), .IDX_WIDTH(IW)
  ) u_dut (
    .clk(clk), .reset(reset),
    .vblank_start(vblank_start),
    .cpu_mem_din_addr(cpu_mem_din_addr),
    .cpu_mem_din(cpu_mem_din),
    .cpu_mem_dout_we(cpu_mem_dout_we),
    .cpu_mem_dout_addr(cpu_mem_dout_addr),
    .cpu_mem_dout(cpu_mem_dout),
    .cpu_halt(cpu_halt),
    .mem_dout_addr(mem_dout_addr),
    .mem_dout(mem_dout),
    .mem_we(mem_we),
    .mem_din_addr(mem_din_addr),
    .mem_din(mem_din),
    .dma_valid(dma_valid),
    .dma_index(dma_index),
    .dma_data(dma_data),
    .dma_done(dma_done)
  );

  always #5 clk = ~clk;

  logic [WW-1:0] mem [0:8191];
  int            wr8_cnt = 0;

  always @(posedge clk) begin
    if (mem_we) mem[mem_din_addr] <= mem_din;
    if (mem_we && mem_din_addr == 13'd8) wr8_cnt <= wr8_cnt + 1;
    mem_dout <= mem[mem_dout_addr];
  end

  typedef struct {
    int            idx;
    logic [WW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  logic [WW-1:0] burst_words [0:3];

  int n_cmp = 0;
  int n_bad = 0;
  int halt_cnt = 0;
  int valid_cnt = 0;
  int done_cnt = 0;

  task automatic check(input string name, input longint act,
                       input longint req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (cpu_halt) halt_cnt <= halt_cnt + 1;
    if (dma_valid) valid_cnt <= valid_cnt + 1;
    if (dma_done) done_cnt <= done_cnt + 1;
    if (cpu_halt) check("we_during_halt", longint'(mem_we), 0);
    if (dma_valid) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_word", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_index", longint'(dma_index), longint'(e.idx));
        check("sb_data", longint'(dma_data), longint'(e.data));
      end
    end
  end

  task automatic push_burst(input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.idx  = i;
      e.data = burst_words[i];
      exp_q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // wait for halt to drop; sits on the first IDLE negedge on return
  task automatic wait_release(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (cpu_halt && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (cpu_halt) check({name, "_timeout"}, 1, 0);
  endtask

  int h0, v0, d0, w0;

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = '0;
    mem[5]    = 16'hBEEF;
    mem[7]    = 16'h55AA;
    mem[8190] = 16'hA1A1;
    mem[8191] = 16'hB2B2;
    mem[0]    = 16'hC3C3;
    mem[1]    = 16'hD4D4;
    burst_words[0] = 16'hA1A1;
    burst_words[1] = 16'hB2B2;
    burst_words[2] = 16'hC3C3;
    burst_words[3] = 16'hD4D4;

    reset = 1'b1;
    vblank_start = 1'b0;
    cpu_mem_din_addr = 13'd7;
    cpu_mem_dout_we = 1'b0;
    cpu_mem_dout_addr = 13'd6;
    cpu_mem_dout = 16'h0;
    step();
    step();
    @(negedge clk);
    check("rst_halt", longint'(cpu_halt), 0);
    check("rst_valid", longint'(dma_valid), 0);
    check("rst_done", longint'(dma_done), 0);
    check("rst_index", longint'(dma_index), 0);
    check("rst_data", longint'(dma_data), 0);
    check("rst_idle_addr", longint'(mem_dout_addr), 7);
    step();
    reset = 1'b0;

    // idle read passthrough
    cpu_mem_din_addr = 13'd5;
    step();
    @(negedge clk);
    check("idle_read", longint'(cpu_mem_din), 16'hBEEF);

    // idle write passthrough
    step();
    cpu_mem_dout_we = 1'b1;
    cpu_mem_dout_addr = 13'd6;
    cpu_mem_dout = 16'h1234;
    @(negedge clk);
    check("idle_we", longint'(mem_we), 1);
    step();
    check("idle_write", longint'(mem[6]), 16'h1234);
    cpu_mem_dout_we = 1'b0;

    // burst 1: coincident write, second vblank ignored, resume read
    step();
    h0 = halt_cnt; v0 = valid_cnt; d0 = done_cnt;
    cpu_mem_din_addr = 13'd7;
    cpu_mem_dout_we = 1'b1;
    cpu_mem_dout_addr = 13'd9;
    cpu_mem_dout = 16'h7777;
    vblank_start = 1'b1;
    push_burst(LEN);
    @(negedge clk);
    check("coll_we", longint'(mem_we), 1);
    step();
    vblank_start = 1'b0;
    cpu_mem_dout_we = 1'b0;
    check("coll_write", longint'(mem[9]), 16'h7777);
    step();
    vblank_start = 1'b1;
    step();
    vblank_start = 1'b0;
    wait_release("b1");
    check("b1_resume_read", longint'(cpu_mem_din), 16'h55AA);
    check("b1_done", longint'(dma_done), 1);
    check("b1_done_novalid", longint'(dma_valid), 0);
    repeat (8) @(negedge clk);
    check("b1_halt_cycles", longint'(halt_cnt - h0), LEN + 1);
    check("b1_words", longint'(valid_cnt - v0), LEN);
    check("b1_done_count", longint'(done_cnt - d0), 1);
    check("b1_sb_empty", longint'(exp_q.size()), 0);

    // burst 2: write held across the halt commits once afterwards
    step();
    w0 = wr8_cnt;
    cpu_mem_din_addr = 13'd7;
    vblank_start = 1'b1;
    push_burst(LEN);
    step();
    vblank_start = 1'b0;
    cpu_mem_dout_we = 1'b1;
    cpu_mem_dout_addr = 13'd8;
    cpu_mem_dout = 16'h0F0F;
    wait_release("b2");
    check("b2_resume_read", longint'(cpu_mem_din), 16'h55AA);
    check("b2_we_release", longint'(mem_we), 1);
    step();
    cpu_mem_dout_we = 1'b0;
    check("b2_mem8", longint'(mem[8]), 16'h0F0F);
    check("b2_write_once", longint'(wr8_cnt - w0), 1);
    check("b2_sb_empty", longint'(exp_q.size()), 0);

    // reset during the second FETCH cycle
    step();
    vblank_start = 1'b1;
    push_burst(1);
    step();
    vblank_start = 1'b0;
    step();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_halt", longint'(cpu_halt), 0);
    check("mid_rst_valid", longint'(dma_valid), 0);
    check("mid_rst_done", longint'(dma_done), 0);
    check("mid_rst_idle_addr", longint'(mem_dout_addr), 7);
    step();
    reset = 1'b0;
    check("mid_rst_sb_empty", longint'(exp_q.size()), 0);

    // full burst after reset
    step();
    h0 = halt_cnt; v0 = valid_cnt; d0 = done_cnt;
    vblank_start = 1'b1;
    push_burst(LEN);
    step();
    vblank_start = 1'b0;
    wait_release("b3");
    repeat (4) @(negedge clk);
    check("b3_halt_cycles", longint'(halt_cnt - h0), LEN + 1);
    check("b3_words", longint'(valid_cnt - v0), LEN);
    check("b3_done_count", longint'(done_cnt - d0), 1);
    check("b3_sb_empty", longint'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
